// File: rtl/memory_stage.sv
// Memory pipeline stage: stack push/pop, CALL/RET/RTI sequencing, LDD/STD, writeback register.
// Define STACK_BOUNDS_CHECK_EN to enable stack-bound faults reported on StackErr.
module memory_stage #(
  parameter logic [15:0] SP_INIT     = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hF000
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic [105:0] In,
  output logic [15:0]  DMemAddr,
  output logic [15:0]  DMemWData,
  output logic         DMemWE,
  input  logic [15:0]  DMemRData,
  output logic         Stall,
  output logic         WB_En,
  output logic [2:0]   WB_Addr,
  output logic [15:0]  WB_Data,
  output logic         PC_Load,
  output logic [31:0]  PC_Value,
  output logic         RestoreFlags,
  output logic         StackErr
);
  typedef enum logic [1:0] {IDLE, CALL2, RET2} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_sp, w_sp_n, r_lat, w_lat_n;
  logic        r_rti, w_rti_n;
  logic        r_wb_en, w_wb_en_n, r_pc_load, w_pc_load_n, r_rf, w_rf_n, r_err, w_err;
  logic [2:0]  r_wb_addr, w_wb_addr_n;
  logic [15:0] r_wb_data, w_wb_data_n;
  logic [31:0] r_pc_val, w_pc_val_n;
  logic [15:0] w_addr, w_wdata;
  logic        w_we, w_stall;

  wire [15:0] w_inport = In[98:83];
  wire [31:0] w_npc    = In[82:51];
  wire [15:0] w_rsrc   = In[50:35];
  wire [15:0] w_alu    = In[34:19];
  wire [2:0]  w_rdst   = In[15:13];
  wire        w_unused = ^{In[105:99], In[18:16], In[12], In[5:4]};

  // 17-bit so overflow past SP_INIT / underflow below zero stays visible to the bound checks
  wire [16:0] w_sp_m1 = {1'b0, r_sp} - 17'd1;
  wire [16:0] w_sp_p1 = {1'b0, r_sp} + 17'd1;
  wire [16:0] w_sp_p2 = {1'b0, r_sp} + 17'd2;

  logic w_wr0_err, w_wrm1_err, w_rdp1_err, w_rdp2_err;
`ifdef STACK_BOUNDS_CHECK_EN
  assign w_wr0_err  = r_sp < STACK_LIMIT;
  assign w_wrm1_err = w_sp_m1[16] || (w_sp_m1[15:0] < STACK_LIMIT);
  assign w_rdp1_err = w_sp_p1 > {1'b0, SP_INIT};
  assign w_rdp2_err = w_sp_p2 > {1'b0, SP_INIT};
`else
  assign w_wr0_err  = 1'b0;
  assign w_wrm1_err = 1'b0;
  assign w_rdp1_err = 1'b0;
  assign w_rdp2_err = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_sp_n      = r_sp;
    w_lat_n     = r_lat;
    w_rti_n     = r_rti;
    w_addr      = w_alu;
    w_wdata     = w_rsrc;
    w_we        = 1'b0;
    w_stall     = 1'b0;
    w_err       = 1'b0;
    w_wb_en_n   = 1'b0;
    w_wb_addr_n = r_wb_addr;
    w_wb_data_n = r_wb_data;
    w_pc_load_n = 1'b0;
    w_pc_val_n  = r_pc_val;
    w_rf_n      = 1'b0;
    case (r_state)
      IDLE: begin
        w_wb_addr_n = w_rdst;
        w_wb_data_n = In[6] ? w_inport : w_alu;
        if (In[3]) begin
          w_addr  = r_sp;
          w_wdata = w_npc[31:16];
          if (w_wr0_err) w_err = 1'b1;
          else begin
            w_we    = 1'b1;
            w_stall = 1'b1;
            w_lat_n = w_npc[15:0];
            w_next  = CALL2;
          end
        end else if (In[8] || In[9]) begin
          w_addr = w_sp_p1[15:0];
          if (w_rdp1_err) w_err = 1'b1;
          else begin
            w_stall = 1'b1;
            w_lat_n = DMemRData;
            w_rti_n = In[8];
            w_next  = RET2;
          end
        end else if (In[11]) begin
          w_addr = r_sp;
          if (w_wr0_err) w_err = 1'b1;
          else begin
            w_we   = 1'b1;
            w_sp_n = w_sp_m1[15:0];
          end
        end else if (In[10]) begin
          w_addr = w_sp_p1[15:0];
          if (w_rdp1_err) w_err = 1'b1;
          else begin
            w_sp_n      = w_sp_p1[15:0];
            w_wb_data_n = DMemRData;
            w_wb_en_n   = In[0];
          end
        end else if (In[1]) begin
          w_we      = 1'b1;
          w_wb_en_n = In[0];
        end else if (In[2]) begin
          w_wb_data_n = DMemRData;
          w_wb_en_n   = In[0];
        end else begin
          w_wb_en_n = In[0];
        end
      end
      CALL2: begin
        w_addr  = w_sp_m1[15:0];
        w_wdata = r_lat;
        w_next  = IDLE;
        if (w_wrm1_err) w_err = 1'b1;
        else begin
          w_we   = 1'b1;
          w_sp_n = r_sp - 16'd2;
        end
      end
      RET2: begin
        w_addr = w_sp_p2[15:0];
        w_next = IDLE;
        if (w_rdp2_err) w_err = 1'b1;
        else begin
          w_sp_n      = w_sp_p2[15:0];
          w_pc_load_n = 1'b1;
          w_pc_val_n  = {DMemRData, r_lat};
          w_rf_n      = r_rti;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_sp      <= SP_INIT;
      r_lat     <= 16'h0;
      r_rti     <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= 3'h0;
      r_wb_data <= 16'h0;
      r_pc_load <= 1'b0;
      r_pc_val  <= 32'h0;
      r_rf      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sp      <= w_sp_n;
      r_lat     <= w_lat_n;
      r_rti     <= w_rti_n;
      r_wb_en   <= w_wb_en_n;
      r_wb_addr <= w_wb_addr_n;
      r_wb_data <= w_wb_data_n;
      r_pc_load <= w_pc_load_n;
      r_pc_val  <= w_pc_val_n;
      r_rf      <= w_rf_n;
      r_err     <= r_err | w_err;
    end
  end

  // Reset gates the combinational strobes so nothing reaches memory mid-reset
  assign DMemAddr     = w_addr;
  assign DMemWData    = w_wdata;
  assign DMemWE       = w_we & ~Reset;
  assign Stall        = w_stall & ~Reset;
  assign WB_En        = r_wb_en;
  assign WB_Addr      = r_wb_addr;
  assign WB_Data      = r_wb_data;
  assign PC_Load      = r_pc_load;
  assign PC_Value     = r_pc_val;
  assign RestoreFlags = r_rf;
  assign StackErr     = r_err;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a behavioural word memory attached.
module tb_memory_stage;
  logic         CLK = 1'b0;
  logic         Reset;
  logic [105:0] In;
  logic [15:0]  DMemAddr, DMemWData, DMemRData;
  logic         DMemWE, Stall, WB_En, PC_Load, RestoreFlags, StackErr;
  logic [2:0]   WB_Addr;
  logic [15:0]  WB_Data;
  logic [31:0]  PC_Value;

  logic [15:0] t_inport, t_rsrc, t_alu;
  logic [31:0] t_npc;
  logic [2:0]  t_rdst;
  logic t_push, t_pop, t_ret, t_rti, t_ldd, t_in, t_call, t_mrd, t_mwr, t_wb;
  logic        tb_we;
  logic [15:0] tb_addr, tb_data;
  logic [15:0] mem [0:65535];
  int nchk = 0, nerr = 0;

  assign In = {7'b0, t_inport, t_npc, t_rsrc, t_alu, 3'b0, t_rdst, 1'b0,
               t_push, t_pop, t_ret, t_rti, t_ldd, t_in, 2'b0, t_call, t_mrd, t_mwr, t_wb};

  memory_stage dut (
    .CLK(CLK), .Reset(Reset), .In(In), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemWE(DMemWE), .DMemRData(DMemRData), .Stall(Stall), .WB_En(WB_En),
    .WB_Addr(WB_Addr), .WB_Data(WB_Data), .PC_Load(PC_Load), .PC_Value(PC_Value),
    .RestoreFlags(RestoreFlags), .StackErr(StackErr)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (DMemWE) mem[DMemAddr] <= DMemWData;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end
  assign DMemRData = mem[DMemAddr];

  task automatic clr();
    t_inport = 0; t_npc = 0; t_rsrc = 0; t_alu = 0; t_rdst = 0;
    t_push = 0; t_pop = 0; t_ret = 0; t_rti = 0; t_ldd = 0; t_in = 0;
    t_call = 0; t_mrd = 0; t_mwr = 0; t_wb = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clr(); tb_we = 0; tb_addr = 0; tb_data = 0;
    Reset = 0;
    #1 Reset = 1;
    // preload mem[0000] while reset holds the DUT off the bus
    @(negedge CLK); tb_we = 1; tb_addr = 16'h0000; tb_data = 16'h7777;
    t_call = 1; t_npc = 32'h1111_2222;
    @(negedge CLK); tb_we = 0;
    check("rst_stall", Stall, 0);
    check("rst_we", DMemWE, 0);
    check("rst_wben", WB_En, 0);
    check("rst_wbaddr", WB_Addr, 0);
    check("rst_wbdata", WB_Data, 0);
    check("rst_pcload", PC_Load, 0);
    check("rst_pcval", PC_Value, 0);
    check("rst_rf", RestoreFlags, 0);
    check("rst_err", StackErr, 0);
    check("rst_sp", dut.r_sp, 16'hFFFF);
    clr(); Reset = 0;

    // PUSH 1234
    @(negedge CLK); t_push = 1; t_rsrc = 16'h1234; t_wb = 1;
    #1 check("push_we", DMemWE, 1); check("push_addr", DMemAddr, 16'hFFFF);
    @(posedge CLK); #1;
    check("push_mem", mem[16'hFFFF], 16'h1234);
    check("push_sp", dut.r_sp, 16'hFFFE);
    check("push_wben", WB_En, 0);

    // POP into r3
    @(negedge CLK); clr(); t_pop = 1; t_rdst = 3; t_wb = 1;
    #1 check("pop_addr", DMemAddr, 16'hFFFF); check("pop_we", DMemWE, 0);
    @(posedge CLK); #1;
    check("pop_data", WB_Data, 16'h1234);
    check("pop_waddr", WB_Addr, 3);
    check("pop_wben", WB_En, 1);
    check("pop_sp", dut.r_sp, 16'hFFFF);

    // ALU passthrough, then IN port
    @(negedge CLK); clr(); t_alu = 16'hBEEF; t_rdst = 5; t_wb = 1;
    @(posedge CLK); #1;
    check("alu_data", WB_Data, 16'hBEEF); check("alu_addr", WB_Addr, 5); check("alu_wben", WB_En, 1);
    @(negedge CLK); clr(); t_in = 1; t_inport = 16'hC0DE; t_alu = 16'h1111; t_wb = 1;
    @(posedge CLK); #1;
    check("in_data", WB_Data, 16'hC0DE);

    // STD then LDD at 0100
    @(negedge CLK); clr(); t_mwr = 1; t_alu = 16'h0100; t_rsrc = 16'h5555;
    #1 check("std_addr", DMemAddr, 16'h0100);
    @(posedge CLK); #1;
    check("std_mem", mem[16'h0100], 16'h5555);
    check("std_sp", dut.r_sp, 16'hFFFF);
    @(negedge CLK); clr(); t_mrd = 1; t_alu = 16'h0100; t_rdst = 2; t_wb = 1;
    @(posedge CLK); #1;
    check("ldd_data", WB_Data, 16'h5555);

    // PUSH outranks STD when both set; POP restores SP
    @(negedge CLK); clr(); t_push = 1; t_mwr = 1; t_alu = 16'h0200; t_rsrc = 16'h6666;
    #1 check("prio_addr", DMemAddr, 16'hFFFF);
    @(posedge CLK); #1;
    check("prio_sp", dut.r_sp, 16'hFFFE);
    @(negedge CLK); clr(); t_pop = 1; t_wb = 1;
    @(posedge CLK); #1;
    check("prio_pop", WB_Data, 16'h6666);

    // CALL ABCD0042
    @(negedge CLK); clr(); t_call = 1; t_npc = 32'hABCD_0042; t_wb = 1;
    #1 check("call1_stall", Stall, 1); check("call1_addr", DMemAddr, 16'hFFFF);
    check("call1_wdata", DMemWData, 16'hABCD); check("call1_we", DMemWE, 1);
    @(posedge CLK); #1;
    check("call2_stall", Stall, 0); check("call2_addr", DMemAddr, 16'hFFFE);
    check("call2_wdata", DMemWData, 16'h0042); check("call2_we", DMemWE, 1);
    @(negedge CLK); clr();
    @(posedge CLK); #1;
    check("call_memhi", mem[16'hFFFF], 16'hABCD);
    check("call_memlo", mem[16'hFFFE], 16'h0042);
    check("call_sp", dut.r_sp, 16'hFFFD);
    check("call_wben", WB_En, 0);
    check("call_stall_end", Stall, 0);

    // RTI
    @(negedge CLK); t_rti = 1; t_wb = 1;
    #1 check("rti1_stall", Stall, 1); check("rti1_addr", DMemAddr, 16'hFFFE);
    @(posedge CLK); #1;
    check("rti2_stall", Stall, 0); check("rti2_addr", DMemAddr, 16'hFFFF);
    check("rti2_we", DMemWE, 0); check("rti2_pcload", PC_Load, 0);
    @(negedge CLK); clr();
    @(posedge CLK); #1;
    check("rti_pcload", PC_Load, 1);
    check("rti_rf", RestoreFlags, 1);
    check("rti_pcval", PC_Value, 32'hABCD_0042);
    check("rti_sp", dut.r_sp, 16'hFFFF);
    check("rti_wben", WB_En, 0);
    @(posedge CLK); #1;
    check("rti_pcload_off", PC_Load, 0);
    check("rti_rf_off", RestoreFlags, 0);

    // Reset pulse during CALL2 aborts the second write
    @(negedge CLK); t_call = 1; t_npc = 32'h1111_2222;
    @(posedge CLK); #2 Reset = 1;
    #1 check("abort_we", DMemWE, 0); check("abort_stall", Stall, 0);
    @(negedge CLK); clr();
    @(negedge CLK); Reset = 0;
    #1;
    check("abort_memlo", mem[16'hFFFE], 16'h0042);
    check("abort_memhi", mem[16'hFFFF], 16'h1111);
    check("abort_sp", dut.r_sp, 16'hFFFF);
    check("abort_pcload", PC_Load, 0);
    check("abort_pcval", PC_Value, 0);
    check("abort_wben", WB_En, 0);
    check("abort_stall2", Stall, 0);

    // POP at top of stack
    @(negedge CLK); t_pop = 1; t_rdst = 4; t_wb = 1;
    @(posedge CLK); #1;
`ifdef STACK_BOUNDS_CHECK_EN
    check("ovf_err", StackErr, 1);
    check("ovf_wben", WB_En, 0);
    check("ovf_sp", dut.r_sp, 16'hFFFF);
`else
    check("wrap_data", WB_Data, 16'h7777);
    check("wrap_wben", WB_En, 1);
    check("wrap_sp", dut.r_sp, 16'h0000);
    check("wrap_err", StackErr, 0);
`endif
    @(negedge CLK); clr();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
